// File: rtl/jellyvl_etherneco_synctimer_slave_if.sv
// Byte-stream bundle used between Etherneco ring nodes: one byte per cycle
// with packet framing flags and no backpressure.
interface jellyvl_etherneco_synctimer_slave_if;
  logic       first;
  logic       last;
  logic       valid;
  logic [7:0] data;

  modport master (output first, last, valid, data);
  modport slave  (input  first, last, valid, data);
endinterface

// File: rtl/jellyvl_etherneco_synctimer_slave.sv
// Sync-timer slave: keeps a fractional-step local timer, snoops 11-byte sync
// packets on the ring to steer it, and forwards the stream with hop count bumped.
module jellyvl_etherneco_synctimer_slave #(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 8,
  parameter int DENOMINATOR = 1,
  parameter int OFFSET      = 0,
  parameter int ADJ_LIMIT   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic [TIMER_WIDTH-1:0]              current_time,
  jellyvl_etherneco_synctimer_slave_if.slave  s_rx,
  jellyvl_etherneco_synctimer_slave_if.master m_tx,
  output logic                                sync_valid,
  output logic                                sync_error
);

  localparam int FRAC_WIDTH = $clog2(DENOMINATOR) + 1;
  localparam int STEP_INT   = NUMERATOR / DENOMINATOR;
  localparam int STEP_REM   = NUMERATOR % DENOMINATOR;

  localparam logic [TIMER_WIDTH-1:0] STEP_INT_T = TIMER_WIDTH'(STEP_INT);
  localparam logic [TIMER_WIDTH-1:0] ONE_T      = TIMER_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0] OFFSET_T   = TIMER_WIDTH'(OFFSET);
  localparam logic [TIMER_WIDTH-1:0] LIMIT_T    = TIMER_WIDTH'(ADJ_LIMIT);
  localparam logic [FRAC_WIDTH-1:0]  STEP_REM_F = FRAC_WIDTH'(STEP_REM);
  localparam logic [FRAC_WIDTH-1:0]  DENOM_F    = FRAC_WIDTH'(DENOMINATOR);
  localparam logic signed [65:0]     LIMIT_POS  = 66'(ADJ_LIMIT);
  localparam logic signed [65:0]     LIMIT_NEG  = -LIMIT_POS;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             index_q, index_d;
  logic                   override_q, override_d;
  logic [63:0]            rxTime_q, rxTime_d;
  logic [FRAC_WIDTH-1:0]  frac_q, frac_d;
  logic [TIMER_WIDTH-1:0] time_q, time_d;
  logic                   syncValid_q, syncError_q, syncError_d;
  logic                   complete;
  logic                   txFirst_q, txLast_q, txValid_q;
  logic [7:0]             txData_q, txData_d;

  logic [FRAC_WIDTH-1:0]  fracSum;
  logic                   fracCarry;
  logic [TIMER_WIDTH-1:0] step;
  logic [TIMER_WIDTH-1:0] nominal;
  logic [TIMER_WIDTH-1:0] target;
  logic [TIMER_WIDTH-1:0] timeErr;
  logic [TIMER_WIDTH-1:0] adjust;
  logic signed [65:0]     errExt;

  // Parser: byte index tracks the position of the next byte within a packet.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    override_d  = override_q;
    rxTime_d    = rxTime_q;
    complete    = 1'b0;
    syncError_d = 1'b0;
    if (s_rx.valid) begin
      if (s_rx.first) begin
        if (s_rx.last) begin
          state_d     = IDLE;
          index_d     = 4'd0;
          syncError_d = 1'b1;
        end else begin
          state_d = RECV;
          index_d = 4'd1;
        end
      end else if (state_q == RECV) begin
        if (index_q == 4'd1) begin
          override_d = s_rx.data[0];
        end
        for (int k = 0; k < 8; k++) begin
          if (index_q == 4'(k + 2)) begin
            rxTime_d[8*k +: 8] = s_rx.data;
          end
        end
        if (s_rx.last) begin
          state_d = IDLE;
          index_d = 4'd0;
          if (index_q == 4'd10) begin
            complete = 1'b1;
          end else begin
            syncError_d = 1'b1;
          end
        end else if (index_q == 4'd10) begin
          state_d     = DROP;
          index_d     = 4'd0;
          syncError_d = 1'b1;
        end else begin
          index_d = index_q + 4'd1;
        end
      end else if ((state_q == DROP) && s_rx.last) begin
        state_d = IDLE;
      end
    end
  end

  // Timer: fractional carry stretches the step; a completed packet replaces
  // the normal increment with either a hard load or a clamped nudge.
  always_comb begin
    fracSum   = frac_q + STEP_REM_F;
    fracCarry = (fracSum >= DENOM_F);
    frac_d    = fracCarry ? (fracSum - DENOM_F) : fracSum;
    step      = STEP_INT_T + (fracCarry ? ONE_T : '0);
    nominal   = time_q + step;
    target    = rxTime_q[TIMER_WIDTH-1:0] + OFFSET_T;
    timeErr   = target - nominal;
    errExt    = {{(66-TIMER_WIDTH){timeErr[TIMER_WIDTH-1]}}, timeErr};
    if (errExt > LIMIT_POS) begin
      adjust = LIMIT_T;
    end else if (errExt < LIMIT_NEG) begin
      adjust = -LIMIT_T;
    end else begin
      adjust = timeErr;
    end
    time_d = nominal;
    if (complete) begin
      time_d = override_q ? target : (nominal + adjust);
    end
  end

  // The first byte of every packet carries the hop count.
  always_comb begin
    txData_d = s_rx.data;
    if (s_rx.first && s_rx.valid && (s_rx.data != 8'hFF)) begin
      txData_d = s_rx.data + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= 4'd0;
      override_q  <= 1'b0;
      rxTime_q    <= '0;
      frac_q      <= '0;
      time_q      <= '0;
      syncValid_q <= 1'b0;
      syncError_q <= 1'b0;
      txFirst_q   <= 1'b0;
      txLast_q    <= 1'b0;
      txValid_q   <= 1'b0;
      txData_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      override_q  <= override_d;
      rxTime_q    <= rxTime_d;
      frac_q      <= frac_d;
      time_q      <= time_d;
      syncValid_q <= complete;
      syncError_q <= syncError_d;
      txFirst_q   <= s_rx.first;
      txLast_q    <= s_rx.last;
      txValid_q   <= s_rx.valid;
      txData_q    <= txData_d;
    end
  end

  assign current_time = time_q;
  assign sync_valid   = syncValid_q;
  assign sync_error   = syncError_q;
  assign m_tx.first   = txFirst_q;
  assign m_tx.last    = txLast_q;
  assign m_tx.valid   = txValid_q;
  assign m_tx.data    = txData_q;

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave.sv
// Bench for the sync-timer slave: one instance with OFFSET=5 for packet
// handling and forwarding, one with a 10/3 clock period for the fractional step.
module tb_jellyvl_etherneco_synctimer_slave;

  localparam int OFFSET = 5;

  typedef struct {
    logic        rst;
    logic        first;
    logic        last;
    logic        valid;
    logic [7:0]  data;
    logic        expValid;
    logic        expError;
    logic [63:0] expTime;
  } vec_t;

  typedef struct {
    logic        first;
    logic        last;
    logic        valid;
    logic [7:0]  data;
    logic        syncValid;
    logic        syncError;
    logic [63:0] timeVal;
  } expOut_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mainTime;
  logic [63:0] fracTime;
  logic        mainSyncValid, mainSyncError;
  logic        fracSyncValid, fracSyncError;

  vec_t        vecs[$];
  expOut_t     expQ[$];
  logic [63:0] modelTime;
  int          checks   = 0;
  int          failures = 0;

  jellyvl_etherneco_synctimer_slave_if rxMain ();
  jellyvl_etherneco_synctimer_slave_if txMain ();
  jellyvl_etherneco_synctimer_slave_if rxFrac ();
  jellyvl_etherneco_synctimer_slave_if txFrac ();

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_slave #(
    .TIMER_WIDTH (64),
    .NUMERATOR   (8),
    .DENOMINATOR (1),
    .OFFSET      (OFFSET),
    .ADJ_LIMIT   (16)
  ) dutMain (
    .clk          (clk),
    .reset        (reset),
    .current_time (mainTime),
    .s_rx         (rxMain),
    .m_tx         (txMain),
    .sync_valid   (mainSyncValid),
    .sync_error   (mainSyncError)
  );

  jellyvl_etherneco_synctimer_slave #(
    .TIMER_WIDTH (64),
    .NUMERATOR   (10),
    .DENOMINATOR (3),
    .OFFSET      (0),
    .ADJ_LIMIT   (16)
  ) dutFrac (
    .clk          (clk),
    .reset        (reset),
    .current_time (fracTime),
    .s_rx         (rxFrac),
    .m_tx         (txFrac),
    .sync_valid   (fracSyncValid),
    .sync_error   (fracSyncError)
  );

  // Reference for the forwarded byte: hop count incremented, saturating.
  function automatic logic [7:0] fwdData(input logic first, input logic valid, input logic [7:0] d);
    if (first && valid && (d != 8'hFF)) return d + 8'd1;
    return d;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushBeat(input logic rst, input logic first, input logic last, input logic valid,
                          input logic [7:0] data, input logic expValid, input logic expError,
                          input logic [63:0] expTime);
    vec_t v;
    v.rst      = rst;
    v.first    = first;
    v.last     = last;
    v.valid    = valid;
    v.data     = data;
    v.expValid = expValid;
    v.expError = expError;
    v.expTime  = expTime;
    vecs.push_back(v);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) pushBeat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 64'd0);
  endtask

  // Back-to-back packet beats; errAt/rstAt of -1 means none.
  task automatic pushPacket(input logic [7:0] hop, input logic override, input logic [63:0] t,
                            input int len, input int errAt, input int rstAt,
                            input logic expSync, input logic [63:0] expTime);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i == 0)       b = hop;
      else if (i == 1)  b = {7'h00, override};
      else if (i <= 9)  b = t[8*(i-2) +: 8];
      else if (i == 10) b = 8'h00;
      else              b = 8'h5A;
      pushBeat(i == rstAt, i == 0, i == len - 1, 1'b1, b, expSync && (i == 10), i == errAt, expTime);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    expOut_t e;
    reset       = v.rst;
    rxMain.first = v.first;
    rxMain.last  = v.last;
    rxMain.valid = v.valid;
    rxMain.data  = v.data;
    if (v.rst) begin
      modelTime   = 64'd0;
      e.first     = 1'b0;
      e.last      = 1'b0;
      e.valid     = 1'b0;
      e.data      = 8'h00;
      e.syncValid = 1'b0;
      e.syncError = 1'b0;
    end else begin
      modelTime   = v.expValid ? v.expTime : modelTime + 64'd8;
      e.first     = v.first;
      e.last      = v.last;
      e.valid     = v.valid;
      e.data      = fwdData(v.first, v.valid, v.data);
      e.syncValid = v.expValid;
      e.syncError = v.expError;
    end
    e.timeVal = modelTime;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    expOut_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = expQ.pop_front();
    checkVal("tx_first",     64'(txMain.first),  64'(e.first));
    checkVal("tx_last",      64'(txMain.last),   64'(e.last));
    checkVal("tx_valid",     64'(txMain.valid),  64'(e.valid));
    checkVal("tx_data",      64'(txMain.data),   64'(e.data));
    checkVal("sync_valid",   64'(mainSyncValid), 64'(e.syncValid));
    checkVal("sync_error",   64'(mainSyncError), 64'(e.syncError));
    checkVal("current_time", mainTime,           e.timeVal);
  endtask

  task automatic runVectors();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end
    vecs.delete();
  endtask

  // Non-override packet whose target sits 'lag' ahead of where the local
  // timer would land on the completing cycle (11 beats from now at step 8).
  task automatic syncNonOverride(input longint lag);
    logic [63:0] predicted;
    logic [63:0] t;
    longint      clampVal;
    predicted = modelTime + 64'd88;
    t         = predicted + 64'(lag) - 64'(OFFSET);
    clampVal  = (lag > 16) ? 64'sd16 : ((lag < -16) ? -64'sd16 : lag);
    pushPacket(8'h01, 1'b0, t, 11, -1, -1, 1'b1, predicted + 64'(clampVal));
    pushIdle(1);
    runVectors();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          fracInc[6] = '{3, 3, 4, 3, 3, 4};
    logic [63:0] fracExp;
    vec_t        idle;

    reset        = 1'b1;
    rxMain.first = 1'b0;
    rxMain.last  = 1'b0;
    rxMain.valid = 1'b0;
    rxMain.data  = 8'h00;
    rxFrac.first = 1'b0;
    rxFrac.last  = 1'b0;
    rxFrac.valid = 1'b0;
    rxFrac.data  = 8'h00;
    modelTime    = 64'd0;
    $display("[TB] Starting sync-timer slave test");

    for (int i = 0; i < 3; i++) pushBeat(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 64'd0);
    runVectors();
    checkVal("frac_reset_time", fracTime, 64'd0);

    // Fractional period 10/3 alongside the default 8-per-cycle instance.
    idle    = '{rst: 1'b0, first: 1'b0, last: 1'b0, valid: 1'b0, data: 8'h00,
                expValid: 1'b0, expError: 1'b0, expTime: 64'd0};
    fracExp = 64'd0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(idle);
      checkOutput();
      fracExp = fracExp + 64'(fracInc[i]);
      checkVal("frac_time", fracTime, fracExp);
    end
    checkVal("frac_tx_valid",   64'(txFrac.valid),  64'd0);
    checkVal("frac_sync_valid", 64'(fracSyncValid), 64'd0);
    checkVal("frac_sync_error", 64'(fracSyncError), 64'd0);

    // Main table: stray byte, override, malformed packets, recovery.
    pushBeat(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 64'd0);
    pushPacket(8'h03, 1'b1, 64'h1000, 11, -1, -1, 1'b1, 64'h1005);
    pushIdle(2);
    pushPacket(8'hFF, 1'b1, 64'hDEAD_0000, 7, 6, -1, 1'b0, 64'd0);
    pushIdle(1);
    pushPacket(8'h10, 1'b1, 64'h5555, 12, 10, -1, 1'b0, 64'd0);
    pushBeat(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 64'd0);
    pushPacket(8'h00, 1'b1, 64'h2000, 11, -1, -1, 1'b1, 64'h2005);
    pushIdle(2);
    runVectors();

    syncNonOverride(100);
    syncNonOverride(7);
    syncNonOverride(-30);

    // Reset lands on byte 5; the tail of that packet must be ignored.
    pushPacket(8'h02, 1'b1, 64'h3000, 11, -1, 5, 1'b0, 64'd0);
    pushIdle(1);
    pushPacket(8'h02, 1'b1, 64'h4000, 11, -1, -1, 1'b1, 64'h4005);
    pushIdle(2);
    runVectors();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/jellyvl_etherneco_synctimer_slave.md
JELLYVL_ETHERNECO_SYNCTIMER_SLAVE -- requirements
Module: jellyvl_etherneco_synctimer_slave

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64, local timer bit width (1..64).
REQ-002 SHALL have parameter NUMERATOR, default 8, clock period numerator.
REQ-003 SHALL have parameter DENOMINATOR, default 1, clock period denominator (>=1).
REQ-004 SHALL have parameter OFFSET, default 0, fixed receive-latency compensation added to received time.
REQ-005 SHALL have parameter ADJ_LIMIT, default 16, maximum magnitude of a non-override correction.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port current_time  output  TIMER_WIDTH  local synchronized timer.
REQ-009 SHALL have ports s_rx_first/s_rx_last/s_rx_valid  input  1 each, s_rx_data  input  8  downstream byte stream from upstream node, no backpressure.
REQ-010 SHALL have ports m_tx_first/m_tx_last/m_tx_valid  output  1 each, m_tx_data  output  8  forwarded stream to next node, no backpressure.
REQ-011 SHALL have port sync_valid  output  1  one-cycle pulse when a packet updates the timer.
REQ-012 SHALL have port sync_error  output  1  one-cycle pulse when a packet is discarded.

Function
REQ-013 Packet SHALL be 11 bytes: byte0 hop count, byte1 command (bit0 = override), bytes2..9 master time little-endian 64-bit, byte10 reserved.
REQ-014 Timer SHALL advance each cycle by NUMERATOR/DENOMINATOR: integer part NUMERATOR div DENOMINATOR, plus 1 when fractional accumulator (width clog2(DENOMINATOR)+1) wraps modulo DENOMINATOR.
REQ-015 Parser states SHALL be IDLE, RECV, DROP; byte index counter 0..10.
REQ-016 A valid byte with s_rx_first SHALL start a packet at index 0 from any state (restart aborts the prior packet without sync_error).
REQ-017 RECV SHALL store bytes by index; index 10 with s_rx_last SHALL complete the packet and return to IDLE.
REQ-018 s_rx_last at index <10, or index reaching 10 without s_rx_last, SHALL pulse sync_error; the latter SHALL enter DROP until next s_rx_last or s_rx_first.
REQ-019 Valid bytes in IDLE/DROP without s_rx_first SHALL be ignored (no error pulse).
REQ-020 Received time T SHALL be truncated to TIMER_WIDTH LSBs; target = T + OFFSET modulo 2^TIMER_WIDTH.
REQ-021 Cycle after completing byte, override=1: current_time SHALL equal target exactly.
REQ-022 Override=0: err = target - (current_time + step) as signed TIMER_WIDTH; current_time SHALL become current_time + step + clamp(err, -ADJ_LIMIT, +ADJ_LIMIT).
REQ-023 The update SHALL replace, not add to, that cycle's normal increment; fractional accumulator SHALL advance normally.
REQ-024 sync_valid SHALL pulse in the same cycle current_time takes the updated value.
REQ-025 Forwarding SHALL be a 1-cycle register of all stream signals; byte0 of each packet (s_rx_first) SHALL be forwarded as data+1, saturating at 0xFF; other bytes unchanged; malformed packets forwarded unchanged otherwise.
REQ-026 Timer SHALL wrap modulo 2^TIMER_WIDTH without flag.

Reset
REQ-027 Reset SHALL set current_time=0, fractional accumulator=0, parser IDLE, index 0, all m_tx_* =0, sync_valid=0, sync_error=0.
REQ-028 Reset asserted mid-packet SHALL discard the packet with no sync_valid/sync_error afterwards.

Verification
REQ-029 Defaults, reset released, no input: current_time = 0,8,16,... one step per cycle; NUMERATOR=10, DENOMINATOR=3 -> increments 3,3,4 repeating.
REQ-030 Override packet time 0x1000, OFFSET=5: cycle after last byte current_time=0x1005, sync_valid=1 one cycle.
REQ-031 Non-override, local lags target by 100: correction +16 (ADJ_LIMIT); lag by 7: correction exactly +7; lead by 30: -16.
REQ-032 Packet with s_rx_last at byte 6 -> sync_error pulse, timer unchanged; 12-byte packet -> sync_error at byte 11, later valid packet accepted.
REQ-033 Forward stream: input byte0=0x03 -> m_tx_data=0x04 one cycle later with m_tx_first=1; byte0=0xFF -> 0xFF; other bytes identical.
REQ-034 Reset pulsed at byte 5, then full valid packet: only second packet produces sync_valid, no sync_error.
